// File: rtl/projectile_sim_param.sv
`default_nettype none
// ============================================================================
// Module   : projectile_sim_param
// Purpose  : One throw per launch request. It models ballistic flight with
//            wind, a wall, screen bounds and graded damage. It latches the
//            win/lose result and blocks further throws until a new game.
// Revision : 1.0 - initial release
// ============================================================================
module projectile_sim_param #(
  parameter int TICK_DIV    = 250000,
  parameter int HP_W        = 7,
  parameter int HP_INIT     = 100,
  parameter int DMG_DIRECT  = 30,
  parameter int DMG_GRAZE   = 10,
  parameter int X_LAUNCH_A  = 262,
  parameter int X_LAUNCH_B  = 712,
  parameter int X_TGT_A     = 187,
  parameter int X_TGT_B     = 787,
  parameter int DIRECT_HALF = 25,
  parameter int ZONE_HALF   = 75,
  parameter int Y_LAUNCH    = 384,
  parameter int Y_GROUND    = 472,
  parameter int WALL_XL     = 497,
  parameter int WALL_XR     = 527,
  parameter int WALL_Y      = 384,
  parameter int GRAVITY     = 2
) (
  input  logic            clk60MHz,
  input  logic            rst_n,
  input  logic            launch,
  input  logic            new_game,
  input  logic            turn,
  input  logic [7:0]      power,
  input  logic [4:0]      speed,
  input  logic [3:0]      wind,
  input  logic            local_player,
  output logic [11:0]     xpos_particle,
  output logic [11:0]     ypos_particle,
  output logic [HP_W-1:0] hp_a,
  output logic [HP_W-1:0] hp_b,
  output logic            end_throw,
  output logic [1:0]      hit_type,
  output logic            busy,
  output logic            win,
  output logic            lose
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TICK_DIV - 1);

  localparam logic signed [12:0] c_x_park      = 13'sd1025;
  localparam logic signed [12:0] c_y_park      = 13'sd768;
  localparam logic signed [12:0] c_x_max       = 13'sd1023;
  localparam logic signed [12:0] c_x_launch_a  = 13'(X_LAUNCH_A);
  localparam logic signed [12:0] c_x_launch_b  = 13'(X_LAUNCH_B);
  localparam logic signed [12:0] c_x_tgt_a     = 13'(X_TGT_A);
  localparam logic signed [12:0] c_x_tgt_b     = 13'(X_TGT_B);
  localparam logic signed [12:0] c_direct_half = 13'(DIRECT_HALF);
  localparam logic signed [12:0] c_zone_half   = 13'(ZONE_HALF);
  localparam logic signed [12:0] c_y_launch    = 13'(Y_LAUNCH);
  localparam logic signed [12:0] c_y_ground    = 13'(Y_GROUND);
  localparam logic signed [12:0] c_wall_xl     = 13'(WALL_XL);
  localparam logic signed [12:0] c_wall_xr     = 13'(WALL_XR);
  localparam logic signed [12:0] c_wall_y      = 13'(WALL_Y);
  localparam logic [HP_W-1:0]    c_hp_init     = HP_W'(HP_INIT);
  localparam logic [HP_W-1:0]    c_dmg_direct  = HP_W'(DMG_DIRECT);
  localparam logic [HP_W-1:0]    c_dmg_graze   = HP_W'(DMG_GRAZE);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FLIGHT = 2'd1,
    S_IMPACT = 2'd2,
    S_OVER   = 2'd3
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic signed [12:0]    r_x, r_y, r_dx;
  logic signed [9:0]     r_vy;
  logic                  r_turn;
  logic [HP_W-1:0]       r_hp_a, r_hp_b;
  logic                  r_end_throw, r_win, r_lose;
  logic [1:0]            r_hit_type;

  logic signed [12:0]    w_dx_launch, w_spd, w_tgt, w_diff, w_dist;
  logic signed [14:0]    w_x_sum, w_y_sum;
  logic signed [11:0]    w_vy_sum;
  logic                  w_ground, w_wall, w_oob, w_coll, w_tick, w_over;
  logic [1:0]            w_hit_nxt;
  logic [HP_W-1:0]       w_dmg, w_hp_a_nxt, w_hp_b_nxt;

  function automatic logic signed [12:0] sat13(input logic signed [14:0] v);
    if (v > 15'sd4095)       return 13'sd4095;
    else if (v < -15'sd4096) return 13'b1_0000_0000_0000;
    else                     return v[12:0];
  endfunction

  function automatic logic signed [9:0] sat_vy(input logic signed [11:0] v);
    if (v > 12'sd511)       return 10'sd511;
    else if (v < -12'sd511) return -10'sd511;
    else                    return v[9:0];
  endfunction

  assign w_spd       = {8'd0, speed};
  assign w_dx_launch = (turn ? (13'sd0 - w_spd) : w_spd) + {{9{wind[3]}}, wind};
  assign w_x_sum     = {{2{r_x[12]}}, r_x} + {{2{r_dx[12]}}, r_dx};
  assign w_y_sum     = {{2{r_y[12]}}, r_y} + {{5{r_vy[9]}}, r_vy};
  assign w_vy_sum    = {{2{r_vy[9]}}, r_vy} + 12'(GRAVITY);
  assign w_tick      = (r_cnt == c_cnt_last);

  // Collision priority is ground, then wall, then screen bounds.
  assign w_ground = (r_y >= c_y_ground);
  assign w_wall   = (r_x >= c_wall_xl) && (r_x <= c_wall_xr) && (r_y >= c_wall_y);
  assign w_oob    = (r_x < 13'sd0) || (r_x > c_x_max);
  assign w_coll   = w_ground || w_wall || w_oob;

  assign w_tgt  = r_turn ? c_x_tgt_a : c_x_tgt_b;
  assign w_diff = r_x - w_tgt;
  assign w_dist = w_diff[12] ? (13'sd0 - w_diff) : w_diff;

  always_comb begin
    w_hit_nxt = 2'd0;
    w_dmg     = '0;
    if (w_ground) begin
      if (w_dist <= c_direct_half) begin
        w_hit_nxt = 2'd2;
        w_dmg     = c_dmg_direct;
      end else if (w_dist <= c_zone_half) begin
        w_hit_nxt = 2'd1;
        w_dmg     = c_dmg_graze;
      end
    end else if (w_wall) begin
      w_hit_nxt = 2'd3;
    end
  end

  always_comb begin
    w_hp_a_nxt = r_hp_a;
    w_hp_b_nxt = r_hp_b;
    if (r_turn) w_hp_a_nxt = (r_hp_a > w_dmg) ? (r_hp_a - w_dmg) : '0;
    else        w_hp_b_nxt = (r_hp_b > w_dmg) ? (r_hp_b - w_dmg) : '0;
  end

  assign w_over = (w_hp_a_nxt == '0) || (w_hp_b_nxt == '0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (launch && !new_game) w_state_nxt = S_FLIGHT;
      S_FLIGHT: if (w_coll) w_state_nxt = S_IMPACT;
      S_IMPACT: w_state_nxt = (w_over && !new_game) ? S_OVER : S_IDLE;
      S_OVER:   if (new_game) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk60MHz) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_x         <= c_x_park;
      r_y         <= c_y_park;
      r_dx        <= '0;
      r_vy        <= '0;
      r_turn      <= 1'b0;
      r_hp_a      <= c_hp_init;
      r_hp_b      <= c_hp_init;
      r_end_throw <= 1'b0;
      r_hit_type  <= 2'd0;
      r_win       <= 1'b0;
      r_lose      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_end_throw <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (launch && !new_game) begin
            r_x    <= turn ? c_x_launch_b : c_x_launch_a;
            r_y    <= c_y_launch;
            r_vy   <= 10'sd0 - $signed({2'b00, power});
            r_cnt  <= '0;
            r_dx   <= w_dx_launch;
            r_turn <= turn;
          end
        end
        S_FLIGHT: begin
          // A detected collision freezes the particle where it is.
          if (!w_coll) begin
            if (w_tick) begin
              r_cnt <= '0;
              r_x   <= sat13(w_x_sum);
              r_y   <= sat13(w_y_sum);
              r_vy  <= sat_vy(w_vy_sum);
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_IMPACT: begin
          r_end_throw <= 1'b1;
          r_hit_type  <= w_hit_nxt;
          r_x         <= c_x_park;
          r_y         <= c_y_park;
          r_hp_a      <= w_hp_a_nxt;
          r_hp_b      <= w_hp_b_nxt;
          if (w_over) begin
            r_win  <= ((w_hp_b_nxt == '0) ? 1'b0 : 1'b1) == local_player;
            r_lose <= ((w_hp_b_nxt == '0) ? 1'b0 : 1'b1) != local_player;
          end
        end
        default: ;
      endcase
      if (new_game) begin
        r_hp_a <= c_hp_init;
        r_hp_b <= c_hp_init;
        r_win  <= 1'b0;
        r_lose <= 1'b0;
      end
    end
  end

  assign xpos_particle = r_x[12] ? 12'd0 : r_x[11:0];
  assign ypos_particle = r_y[12] ? 12'd0 : r_y[11:0];
  assign hp_a          = r_hp_a;
  assign hp_b          = r_hp_b;
  assign end_throw     = r_end_throw;
  assign hit_type      = r_hit_type;
  assign busy          = (r_state == S_FLIGHT) || (r_state == S_IMPACT);
  assign win           = r_win;
  assign lose          = r_lose;

endmodule
`default_nettype wire

// File: tb/tb_projectile_sim_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_projectile_sim_param
// Purpose  : Directed throws with hand-computed trajectories for projectile_sim_param.
// Revision : 1.0 - initial release
// ============================================================================
module tb_projectile_sim_param;

  logic        clk60MHz = 1'b0;
  logic        rst_n = 1'b0;
  logic        launch = 1'b0;
  logic        new_game = 1'b0;
  logic        turn = 1'b0;
  logic [7:0]  power = '0;
  logic [4:0]  speed = '0;
  logic [3:0]  wind = '0;
  logic        local_player = 1'b0;
  logic [11:0] xpos_particle, ypos_particle;
  logic [6:0]  hp_a, hp_b;
  logic        end_throw, busy, win, lose;
  logic [1:0]  hit_type;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk60MHz = ~clk60MHz;

  projectile_sim_param #(
    .TICK_DIV (4),
    .GRAVITY  (8)
  ) u_dut (
    .clk60MHz      (clk60MHz),
    .rst_n         (rst_n),
    .launch        (launch),
    .new_game      (new_game),
    .turn          (turn),
    .power         (power),
    .speed         (speed),
    .wind          (wind),
    .local_player  (local_player),
    .xpos_particle (xpos_particle),
    .ypos_particle (ypos_particle),
    .hp_a          (hp_a),
    .hp_b          (hp_b),
    .end_throw     (end_throw),
    .hit_type      (hit_type),
    .busy          (busy),
    .win           (win),
    .lose          (lose)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Launch one throw and follow it to end_throw; lx/ly hold the frozen impact position.
  task automatic do_throw(input logic t, input int p, input int s, input int w, input int poke,
                          output int cyc, output int lx, output int ly, output int ht);
    bit done;
    done = 1'b0;
    @(negedge clk60MHz);
    turn = t; power = 8'(p); speed = 5'(s); wind = 4'(w); launch = 1'b1;
    @(negedge clk60MHz);
    launch = 1'b0;
    cyc = 0; lx = -1; ly = -1;
    while (!done && cyc < 400) begin
      @(negedge clk60MHz);
      cyc++;
      if (cyc == 1) chk("busy_in_flight", int'(busy), 1);
      if (end_throw) done = 1'b1;
      else begin
        lx = int'(xpos_particle);
        ly = int'(ypos_particle);
      end
      launch = (cyc == poke);
      if (cyc == poke) begin
        turn  = ~t;
        speed = 5'd31;
      end
    end
    launch = 1'b0;
    if (!done) chk("throw_timeout", cyc, -1);
    ht = int'(hit_type);
    @(negedge clk60MHz);
    chk("end_pulse_width", int'(end_throw), 0);
  endtask

  task automatic throw_chk(input string tag, input logic t, input int p, input int s, input int w,
                           input int poke, input int e_cyc, input int e_x, input int e_y,
                           input int e_ht, input int e_a, input int e_b);
    int cyc, lx, ly, ht;
    do_throw(t, p, s, w, poke, cyc, lx, ly, ht);
    chk({tag, "_cycles"}, cyc, e_cyc);
    chk({tag, "_x"}, lx, e_x);
    chk({tag, "_y"}, ly, e_y);
    chk({tag, "_hit"}, ht, e_ht);
    chk({tag, "_hp_a"}, int'(hp_a), e_a);
    chk({tag, "_hp_b"}, int'(hp_b), e_b);
  endtask

  initial begin
    int n_end;
    repeat (2) @(negedge clk60MHz);
    chk("rst_hp_a", int'(hp_a), 100);
    chk("rst_hp_b", int'(hp_b), 100);
    chk("rst_x", int'(xpos_particle), 1025);
    chk("rst_y", int'(ypos_particle), 768);
    chk("rst_busy", int'(busy), 0);
    chk("rst_win", int'(win), 0);
    chk("rst_lose", int'(lose), 0);
    chk("rst_end", int'(end_throw), 0);
    rst_n = 1'b1;

    // tag, turn, power, speed, wind, poke, cycles, x, y, hit, hp_a, hp_b
    throw_chk("miss",       1'b0,   0, 10,  0, -1,  26,  322, 504, 0, 100, 100);
    throw_chk("direct_b",   1'b0,  48, 31,  4, -1,  62,  787, 504, 2, 100,  70);
    throw_chk("graze_b",    1'b0,  48, 31,  1, -1,  62,  742, 504, 1, 100,  60);
    throw_chk("wall",       1'b0,  16, 30,  5, -1,  30,  507, 440, 3, 100,  60);
    throw_chk("direct_a",   1'b1,  48, 31, -4, -1,  62,  187, 504, 2,  70,  60);
    throw_chk("oob_clamp",  1'b1, 200,  0,  7, -1, 182, 1027,   0, 0,  70,  60);
    throw_chk("direct_b2",  1'b0,  48, 31,  4, -1,  62,  787, 504, 2,  70,  30);
    throw_chk("graze_b2",   1'b0,  48, 31,  1, -1,  62,  742, 504, 1,  70,  20);
    throw_chk("final_hit",  1'b0,  48, 31,  4, -1,  62,  787, 504, 2,  70,   0);
    chk("over_win", int'(win), 1);
    chk("over_lose", int'(lose), 0);
    chk("over_busy", int'(busy), 0);

    @(negedge clk60MHz); launch = 1'b1;
    @(negedge clk60MHz); launch = 1'b0;
    repeat (8) @(negedge clk60MHz);
    chk("over_launch_busy", int'(busy), 0);
    chk("over_launch_x", int'(xpos_particle), 1025);
    chk("over_win_held", int'(win), 1);

    new_game = 1'b1; launch = 1'b1;
    @(negedge clk60MHz);
    new_game = 1'b0; launch = 1'b0;
    chk("ng_hp_a", int'(hp_a), 100);
    chk("ng_hp_b", int'(hp_b), 100);
    chk("ng_win", int'(win), 0);
    chk("ng_busy", int'(busy), 0);
    new_game = 1'b1; launch = 1'b1;
    @(negedge clk60MHz);
    new_game = 1'b0; launch = 1'b0;
    @(negedge clk60MHz);
    chk("ng_over_launch_busy", int'(busy), 0);

    throw_chk("poke_ignored", 1'b0,  0, 10,  0,  8,  26,  322, 504, 0, 100, 100);
    throw_chk("direct_b3",    1'b0, 48, 31,  4, -1,  62,  787, 504, 2, 100,  70);

    @(negedge clk60MHz);
    turn = 1'b0; power = 8'd0; speed = 5'd10; wind = 4'd0; launch = 1'b1;
    @(negedge clk60MHz); launch = 1'b0;
    repeat (10) @(negedge clk60MHz);
    chk("mid_busy", int'(busy), 1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk60MHz);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_x", int'(xpos_particle), 1025);
    chk("mid_rst_y", int'(ypos_particle), 768);
    chk("mid_rst_hp_b", int'(hp_b), 100);
    chk("mid_rst_hit", int'(hit_type), 0);
    chk("mid_rst_end", int'(end_throw), 0);
    rst_n = 1'b1;
    n_end = 0;
    repeat (40) begin
      @(negedge clk60MHz);
      if (end_throw) n_end++;
    end
    chk("mid_rst_no_end", n_end, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
